// File: rtl/uart_tx_feeder_pkg.sv
// Shared types for the UartTx feeder: launcher FSM states and the UART byte width.
package uart_tx_feeder_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_SENDING   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Single-clock FIFO with an explicit level counter so full and empty stay distinct
// when the wrapping pointers coincide. Flush overrides any same-cycle push or pop.
module uart_tx_feeder_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  push_en;
  logic                  pop_en;

  assign full_o     = (level_q == FULL_LEVEL);
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign push_en = push_i & ~full_o & ~flush_i;
  assign pop_en  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clock_i) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffered host-side writer for UartTx: queues bytes, launches one write pulse per frame
// and paces on tx_busy_i, flagging dropped bytes and transmitters that never go busy.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                       clock_i,
  input  logic                       reset_n_i,
  input  logic                       flush_i,
  input  logic [UART_DATA_WIDTH-1:0] data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [DEPTH_LOG2:0]        level_o,
  output logic                       empty_o,
  output logic                       overflow_o,
  output logic                       timeout_o,
  output logic                       tx_write_o,
  output logic [UART_DATA_WIDTH-1:0] tx_data_o,
  input  logic                       tx_busy_i
);

  localparam int TIMER_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(BUSY_TIMEOUT);

  tx_state_e                  state_q, state_d;
  logic [TIMER_W-1:0]         timer_q, timer_d;
  logic [TIMER_W-1:0]         timer_inc;
  logic                       overflow_q, overflow_d;
  logic                       timeout_q, timeout_d;
  logic [UART_DATA_WIDTH-1:0] tx_data_q, tx_data_d;

  logic                       fifo_push;
  logic                       fifo_pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [UART_DATA_WIDTH-1:0] fifo_head;

  assign fifo_push = valid_i & ~fifo_full;

  uart_tx_feeder_sync_fifo #(
    .DATA_WIDTH (UART_DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clock_i     (clock_i),
    .reset_n_i   (reset_n_i),
    .flush_i     (flush_i),
    .push_i      (fifo_push),
    .push_data_i (data_i),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level_o)
  );

  assign timer_inc = timer_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    tx_data_d  = tx_data_q;
    fifo_pop   = 1'b0;
    timeout_d  = timeout_q;
    overflow_d = overflow_q | (valid_i & fifo_full);

    case (state_q)
      ST_IDLE: begin
        // A busy transmitter here is a foreign or residual frame: wait it out.
        if (!fifo_empty && !tx_busy_i && !flush_i) begin
          fifo_pop  = 1'b1;
          tx_data_d = fifo_head;
          state_d   = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        timer_d = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy_i) begin
          state_d = ST_SENDING;
        end else begin
          timer_d = timer_inc;
          // The byte is abandoned, not retried, so the queue keeps draining.
          if (timer_inc == TIMER_LIMIT) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_SENDING: begin
        if (!tx_busy_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush_i) begin
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign ready_o    = ~fifo_full;
  assign empty_o    = fifo_empty;
  assign overflow_o = overflow_q;
  assign timeout_o  = timeout_q;
  assign tx_write_o = (state_q == ST_LAUNCH);
  assign tx_data_o  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed plus randomized bench for uart_tx_feeder with a behavioural UartTx model.
module tb_uart_tx_feeder;

  localparam int DEPTH        = 16;
  localparam int BUSY_TIMEOUT = 15;
  localparam int BUSY_LEN     = 10;

  logic       clock_i   = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       flush_i   = 1'b0;
  logic [7:0] data_i    = 8'h00;
  logic       valid_i   = 1'b0;
  logic       ready_o;
  logic [4:0] level_o;
  logic       empty_o;
  logic       overflow_o;
  logic       timeout_o;
  logic       tx_write_o;
  logic [7:0] tx_data_o;
  logic       tx_busy_i;

  logic hold_busy  = 1'b0;
  logic model_busy = 1'b0;
  logic dead       = 1'b0;
  logic pending    = 1'b0;
  logic prev_w     = 1'b0;
  int   busy_cnt   = 0;
  int   writes     = 0;
  int   doubles    = 0;
  logic [7:0] obs_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock_i = ~clock_i;

  assign tx_busy_i = hold_busy | model_busy;

  uart_tx_feeder dut (
    .clock_i    (clock_i),
    .reset_n_i  (reset_n_i),
    .flush_i    (flush_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .level_o    (level_o),
    .empty_o    (empty_o),
    .overflow_o (overflow_o),
    .timeout_o  (timeout_o),
    .tx_write_o (tx_write_o),
    .tx_data_o  (tx_data_o),
    .tx_busy_i  (tx_busy_i)
  );

  // UartTx model: busy rises the cycle after a write pulse and holds for BUSY_LEN cycles.
  always @(negedge clock_i) begin
    prev_w  <= tx_write_o;
    pending <= (tx_write_o === 1'b1) && !dead;
    if (tx_write_o === 1'b1) begin
      writes <= writes + 1;
      obs_q.push_back(tx_data_o);
      if (prev_w) doubles <= doubles + 1;
    end
    if (pending) begin
      model_busy <= 1'b1;
      busy_cnt   <= BUSY_LEN;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else if (busy_cnt == 1) begin
      busy_cnt   <= 0;
      model_busy <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_writes(input int target, input int max_cycles, input string tag);
    int k = 0;
    while (writes < target && k < max_cycles) begin
      tick();
      k++;
    end
    chk(tag, 32'(writes >= target), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},    32'(ready_o),    32'd1);
    chk({tag, "_empty"},    32'(empty_o),    32'd1);
    chk({tag, "_level"},    32'(level_o),    32'd0);
    chk({tag, "_overflow"}, 32'(overflow_o), 32'd0);
    chk({tag, "_timeout"},  32'(timeout_o),  32'd0);
    chk({tag, "_write"},    32'(tx_write_o), 32'd0);
    chk({tag, "_data"},     32'(tx_data_o),  32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int k;
    logic [7:0] first_byte;
    logic [7:0] exp_q[$];

    // Reset state
    repeat (3) tick();
    check_reset_outputs("in_reset");
    reset_n_i = 1'b1;
    tick();
    check_reset_outputs("post_reset");

    // Single byte latency: push at N, write pulse at N+2
    base = writes;
    valid_i = 1'b1;
    data_i  = 8'h55;
    tick();
    valid_i = 1'b0;
    chk("lat_level_n1", 32'(level_o), 32'd1);
    chk("lat_write_n1", 32'(tx_write_o), 32'd0);
    tick();
    chk("lat_write_n2", 32'(tx_write_o), 32'd1);
    chk("lat_data_n2",  32'(tx_data_o),  32'h55);
    chk("lat_level_n2", 32'(level_o),    32'd0);
    tick();
    chk("lat_single_pulse", 32'(tx_write_o), 32'd0);
    chk("lat_data_hold",    32'(tx_data_o),  32'h55);
    repeat (20) tick();
    chk("lat_write_count", 32'(writes - base), 32'd1);

    // Fill while busy is held, then overflow
    hold_busy = 1'b1;
    base = writes;
    for (int i = 0; i < DEPTH; i++) begin
      valid_i = 1'b1;
      data_i  = 8'(i);
      tick();
    end
    chk("full_level", 32'(level_o), 32'd16);
    chk("full_ready", 32'(ready_o), 32'd0);
    chk("full_no_write", 32'(writes - base), 32'd0);
    data_i = 8'hAA;
    tick();
    valid_i = 1'b0;
    chk("ovf_flag",  32'(overflow_o), 32'd1);
    chk("ovf_level", 32'(level_o),    32'd16);
    hold_busy = 1'b0;
    wait_writes(base + DEPTH, DEPTH * 16 + 40, "drain_wait");
    repeat (20) tick();
    chk("drain_count", 32'(writes - base), 32'd16);
    for (int i = 0; i < DEPTH; i++)
      chk($sformatf("drain_order_%0d", i), 32'(obs_q[base + i]), 32'(i));
    chk("drain_empty", 32'(empty_o), 32'd1);

    // Transmitter never goes busy
    dead = 1'b1;
    base = writes;
    valid_i = 1'b1;
    data_i  = 8'h3C;
    tick();
    data_i  = 8'hC3;
    tick();
    valid_i = 1'b0;
    k = 0;
    while (tx_write_o !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    chk("to_first_pulse", 32'(tx_write_o), 32'd1);
    chk("to_first_data",  32'(tx_data_o),  32'h3C);
    chk("to_not_yet",     32'(timeout_o),  32'd0);
    k = 0;
    while (timeout_o !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk("to_latency", 32'(k), 32'(BUSY_TIMEOUT + 1));
    tick();
    chk("to_next_pulse", 32'(tx_write_o), 32'd1);
    chk("to_next_data",  32'(tx_data_o),  32'hC3);
    repeat (BUSY_TIMEOUT + 4) tick();
    dead = 1'b0;
    chk("to_write_count", 32'(writes - base), 32'd2);
    chk("to_sticky",      32'(timeout_o),     32'd1);

    // Flush during SENDING
    base = writes;
    for (int i = 0; i < 6; i++) begin
      valid_i = 1'b1;
      data_i  = 8'($urandom);
      if (i == 0) first_byte = data_i;
      tick();
    end
    valid_i = 1'b0;
    k = 0;
    while (tx_busy_i !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    tick();
    chk("fl_pre_level", 32'(level_o),    32'd5);
    chk("fl_pre_ovf",   32'(overflow_o), 32'd1);
    chk("fl_pre_to",    32'(timeout_o),  32'd1);
    flush_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'hEE;
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("fl_level",    32'(level_o),    32'd0);
    chk("fl_empty",    32'(empty_o),    32'd1);
    chk("fl_ready",    32'(ready_o),    32'd1);
    chk("fl_ovf_clr",  32'(overflow_o), 32'd0);
    chk("fl_to_clr",   32'(timeout_o),  32'd0);
    chk("fl_data_hold", 32'(tx_data_o), 32'(first_byte));
    repeat (40) tick();
    chk("fl_write_count", 32'(writes - base), 32'd1);
    chk("fl_frame_byte",  32'(obs_q[base]),   32'(first_byte));

    // Randomized bursts against an ordered reference queue
    for (int b = 0; b < 5; b++) begin
      int n;
      base = writes;
      exp_q.delete();
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        chk($sformatf("rnd_ready_%0d_%0d", b, i), 32'(ready_o), 32'd1);
        valid_i = 1'b1;
        data_i  = 8'($urandom);
        exp_q.push_back(data_i);
        tick();
        valid_i = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
      wait_writes(base + n, n * 16 + 40, $sformatf("rnd_wait_%0d", b));
      repeat (20) tick();
      chk($sformatf("rnd_count_%0d", b), 32'(writes - base), 32'(n));
      for (int i = 0; i < n; i++)
        chk($sformatf("rnd_byte_%0d_%0d", b, i), 32'(obs_q[base + i]), 32'(exp_q[i]));
    end
    chk("no_double_pulse", 32'(doubles), 32'd0);

    // Asynchronous reset while SENDING
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1;
      data_i  = 8'($urandom);
      tick();
    end
    valid_i = 1'b0;
    k = 0;
    while (tx_busy_i !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    tick();
    chk("rst_pre_level", 32'(level_o), 32'd2);
    base = writes;
    reset_n_i = 1'b0;
    #2;
    check_reset_outputs("async_rst");
    repeat (3) tick();
    reset_n_i = 1'b1;
    repeat (30) tick();
    chk("rst_no_write", 32'(writes - base), 32'd0);
    check_reset_outputs("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
